serial_link: RTL

Game Boy serial port peripheral, a bus neighbour of the CPU alongside the timers and DMA blocks. It decodes the SB (`MMIO_SB`, 0xFF01) and SC (`MMIO_SC`, 0xFF02) registers on the shared `addr_ext`/`data_ext` bus. It shifts one byte in and out, MSB first, on either an internally divided clock or an external link clock. On completion it emits a one-cycle `serial_interrupt`, which the top level wires to `IF_in[I_SERIAL]` and ORs into `IF_load`.

---
 rtl/serial_link_if.sv | 19 +
 rtl/serial_link.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/serial_link_if.sv
// Bus control strobes shared between the CPU and its MMIO neighbours.
// The bidirectional data lines travel beside this interface as a plain inout.
interface serial_link_if;
  logic [15:0] addr_ext;
  logic        mem_re;
  logic        mem_we;

  modport master (
    output addr_ext,
    output mem_re,
    output mem_we
  );

  modport slave (
    input addr_ext,
    input mem_re,
    input mem_we
  );
endinterface

// File: rtl/serial_link.sv
// Game Boy serial port: SB/SC registers, MSB-first byte shifter,
// internal divided clock or synchronised external link clock.
module serial_link #(
  parameter int CLK_DIV = 512
) (
  input  logic         clock,
  input  logic         reset,
  serial_link_if.slave bus,
  inout  wire  [7:0]   data_ext,
  input  logic         sin,
  input  logic         sclk_in,
  output logic         sout,
  output logic         sclk_out,
  output logic         serial_interrupt
);
  localparam int HALF = CLK_DIV / 2;
  localparam int DW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DW-1:0] DIV_TOP = DW'(HALF - 1);
  localparam logic [15:0] MMIO_SB = 16'hFF01;
  localparam logic [15:0] MMIO_SC = 16'hFF02;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [7:0]      sb;
  logic            int_clk;
  logic [DW-1:0]   div;
  logic [2:0]      bit_cnt;
  logic [1:0]      sync;
  logic            sync_prev;

  logic [7:0]      wdata;
  logic [7:0]      rdata;
  logic            sb_we;
  logic            sc_we;
  logic            sb_re;
  logic            sc_re;
  logic            busy;
  logic            div_wrap;
  logic            rise;
  logic            fall;
  logic            done;

  // Bus decode and serial edge selection.
  always_comb begin
    wdata    = data_ext;
    sb_we    = bus.mem_we && (bus.addr_ext == MMIO_SB);
    sc_we    = bus.mem_we && (bus.addr_ext == MMIO_SC);
    sb_re    = bus.mem_re && (bus.addr_ext == MMIO_SB);
    sc_re    = bus.mem_re && (bus.addr_ext == MMIO_SC);
    busy     = (state == SHIFT);
    div_wrap = busy && int_clk && (div == DIV_TOP);
    rise     = 1'b0;
    fall     = 1'b0;
    if (int_clk) begin
      rise = div_wrap && !sclk_out;
      fall = div_wrap && sclk_out;
    end else begin
      rise = busy && sync[1] && !sync_prev;
      fall = busy && !sync[1] && sync_prev;
    end
    done  = rise && (bit_cnt == 3'd7);
    rdata = sb_re ? sb : {busy, 6'h3f, int_clk};
  end

  assign data_ext = (sb_re || sc_re) ? rdata : 8'hzz;

  // Next state: an SC write overrides a completion on the same cycle.
  always_comb begin
    state_nx = state;
    if (sc_we) begin
      state_nx = wdata[7] ? SHIFT : IDLE;
    end else if (done) begin
      state_nx = IDLE;
    end
  end

  // Transfer state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Shifter, divider, synchroniser and pin registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sb               <= 8'h00;
      int_clk          <= 1'b0;
      sout             <= 1'b1;
      sclk_out         <= 1'b1;
      serial_interrupt <= 1'b0;
      div              <= '0;
      bit_cnt          <= 3'd0;
      sync             <= 2'b11;
      sync_prev        <= 1'b1;
    end else begin
      sync             <= {sync[0], sclk_in};
      sync_prev        <= sync[1];
      serial_interrupt <= 1'b0;
      if (sc_we) begin
        int_clk  <= wdata[0];
        sclk_out <= 1'b1;
        if (wdata[7]) begin
          bit_cnt <= 3'd0;
          div     <= '0;
        end else begin
          sout <= 1'b1;
        end
      end else begin
        if (sb_we && !busy) begin
          sb <= wdata;
        end
        if (busy && int_clk) begin
          div <= div_wrap ? '0 : div + DW'(1);
        end
        if (div_wrap) begin
          sclk_out <= ~sclk_out;
        end
        if (fall) begin
          sout <= sb[7];
        end
        if (rise) begin
          sb      <= {sb[6:0], sin};
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (done) begin
          sout             <= 1'b1;
          serial_interrupt <= 1'b1;
        end
      end
    end
  end
endmodule
